// File: rtl/picosoc_bus_pkg.sv
// Shared state encoding and constants for the PicoSoC native-bus interconnect.
package picosoc_bus_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StActive = 2'd1,
      StResp   = 2'd2,
      StErr    = 2'd3
   } bus_state_e;

   localparam int unsigned TMO_W             = 16;
   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/picosoc_bus_decode.sv
// Combinational address decoder: one-hot hit vector plus any_hit, lowest index wins on overlap.
module picosoc_bus_decode #(
   parameter int unsigned             N_SLAVES   = 4,
   parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE = '0,
   parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK = '0
) (
   input  logic [31:0]         addr,
   output logic [N_SLAVES-1:0] hit,
   output logic                any_hit
);

   always_comb begin
      hit     = '0;
      any_hit = 1'b0;
      for (int i = 0; i < int'(N_SLAVES); i++) begin
         if (!any_hit && ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])) begin
            hit[i]  = 1'b1;
            any_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/picosoc_bus_mux.sv
// N-slave picorv32 native-bus interconnect: registered decode, one outstanding transaction.
// Optional slave wait timeout enabled by defining BUS_TIMEOUT_EN.
module picosoc_bus_mux
   import picosoc_bus_pkg::*;
#(
   parameter int unsigned            N_SLAVES       = 4,
   // Slave 0 occupies the LSBs of each flat vector.
   parameter logic [N_SLAVES*32-1:0] SLAVE_BASE     = {32'h0300_0000, 32'h0000_0000,
                                                       32'h0010_0000, 32'h0200_0000},
   parameter logic [N_SLAVES*32-1:0] SLAVE_MASK     = {32'hFF00_0000, 32'hFFFF_FC00,
                                                       32'hFFF0_0000, 32'hFFFF_FF00},
   parameter int unsigned            TIMEOUT_CYCLES = 255,
   parameter logic [31:0]            ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mem_valid,
   input  logic                   mem_instr,
   input  logic [31:0]            mem_addr,
   input  logic [31:0]            mem_wdata,
   input  logic [3:0]             mem_wstrb,
   output logic                   mem_ready,
   output logic [31:0]            mem_rdata,
   output logic                   mem_err,
   output logic [N_SLAVES-1:0]    s_valid,
   output logic                   s_instr,
   output logic [31:0]            s_addr,
   output logic [31:0]            s_wdata,
   output logic [3:0]             s_wstrb,
   input  logic [N_SLAVES-1:0]    s_ready,
   input  logic [N_SLAVES*32-1:0] s_rdata
);

   if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_n_slaves
      $error("picosoc_bus_mux: N_SLAVES must be 1..16");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("picosoc_bus_mux: TIMEOUT_CYCLES must be 1..65535");
   end

   bus_state_e            state_q, state_d;
   logic [N_SLAVES-1:0]   sel_q;
   logic [N_SLAVES-1:0]   dec_hit;
   logic                  dec_any;
   logic                  sel_ready;
   logic [31:0]           sel_rdata;
   logic                  tmo_expired;

   picosoc_bus_decode #(
      .N_SLAVES   (N_SLAVES),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK)
   ) u_decode (
      .addr    (mem_addr),
      .hit     (dec_hit),
      .any_hit (dec_any)
   );

   always_comb begin
      sel_ready = |(s_ready & sel_q);
      sel_rdata = '0;
      for (int i = 0; i < int'(N_SLAVES); i++) begin
         if (sel_q[i]) sel_rdata = sel_rdata | s_rdata[32*i +: 32];
      end
   end

`ifdef BUS_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt_q;

   always_ff @(posedge clk) begin
      if (reset || state_q != StActive) tmo_cnt_q <= '0;
      else if (!sel_ready)              tmo_cnt_q <= tmo_cnt_q + 1'b1;
   end

   assign tmo_expired = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (mem_valid) state_d = dec_any ? StActive : StErr;
         StActive: begin
            // A ready arriving on the timeout cycle still completes normally.
            if (sel_ready)        state_d = StResp;
            else if (tmo_expired) state_d = StErr;
         end
         StResp:   state_d = StIdle;
         StErr:    state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   assign mem_ready = (state_q == StResp) || (state_q == StErr);
   assign mem_err   = (state_q == StErr);
   assign s_valid   = (state_q == StActive) ? sel_q : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         sel_q     <= '0;
         s_addr    <= '0;
         s_wdata   <= '0;
         s_wstrb   <= '0;
         s_instr   <= 1'b0;
         mem_rdata <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && mem_valid) begin
            sel_q   <= dec_hit;
            s_addr  <= mem_addr;
            s_wdata <= mem_wdata;
            s_wstrb <= mem_wstrb;
            s_instr <= mem_instr;
         end
         if (state_d == StErr)       mem_rdata <= ERR_RDATA;
         else if (state_d == StResp) mem_rdata <= sel_rdata;
      end
   end

endmodule
